// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I register-file defaults and types
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_X0 = 0;
  typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/rv_regfile_sb_if.sv
// rv_regfile_sb_if: read ports, WB write port, issue-side scoreboard set and busy view
interface rv_regfile_sb_if import rv_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2
);
  localparam int AW = $clog2(NREGS);
  logic [NRD*AW-1:0] ra;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic we;
  logic [AW-1:0] wa;
  logic [XLEN-1:0] wd;
  logic sb_set;
  logic [AW-1:0] sb_addr;
  logic [NREGS-1:0] busy_vec;
  modport master (output ra, we, wa, wd, sb_set, sb_addr, input rd_data, rd_busy, busy_vec);
  modport slave (input ra, we, wa, wd, sb_set, sb_addr, output rd_data, rd_busy, busy_vec);
endinterface

// File: rtl/rv_regfile_sb_read_port.sv
// rf_read_port: one combinational read port with x0, write-through bypass and array mux
module rf_read_port import rv_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW = $clog2(NREGS)
) (
  input  logic en,
  input  logic [AW-1:0] ra,
  input  logic [NREGS-1:0][XLEN-1:0] rf,
  input  logic [NREGS-1:0] busy,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [XLEN-1:0] wd,
  input  logic sb_set,
  input  logic [AW-1:0] sb_addr,
  output logic [XLEN-1:0] rd_data,
  output logic rd_busy
);
  logic zero, byp;
  always_comb begin
    zero = !en || ra == AW'(REG_X0);
    byp = we && wa == ra;
    rd_data = zero ? '0 : byp ? wd : rf[ra];
    rd_busy = zero ? 1'b0 : byp ? (sb_set && sb_addr == ra) : busy[ra];
  end
endmodule

// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: RV32I integer register file with NRD read ports, 1 write port and busy scoreboard
module rv_regfile_sb import rv_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2
) (
  input logic clk,
  input logic rst,
  rv_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [NREGS-1:0][XLEN-1:0] rf;
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:0] busy;
  assign busy = {busy_q, 1'b0};
  assign bus.busy_vec = busy;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rf <= '0;
      busy_q <= '0;
    end else begin
      if (bus.we && bus.wa != AW'(REG_X0)) rf[bus.wa] <= bus.wd;
      for (int r = 1; r < NREGS; r++)
        if (bus.sb_set && bus.sb_addr == AW'(r)) busy_q[r] <= 1'b1;
        else if (bus.we && bus.wa == AW'(r)) busy_q[r] <= 1'b0;
    end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_port (
      .en(rst),
      .ra(bus.ra[i*AW +: AW]),
      .rf(rf),
      .busy(busy),
      .we(bus.we),
      .wa(bus.wa),
      .wd(bus.wd),
      .sb_set(bus.sb_set),
      .sb_addr(bus.sb_addr),
      .rd_data(bus.rd_data[i*XLEN +: XLEN]),
      .rd_busy(bus.rd_busy[i])
    );
  end
endmodule
